note_tone_gen: RTL

Piano tone generator clocked by the 25 MHz divided clock from the slow-clock divider. Samples eight piano keys, debounces them, picks one note by fixed priority, and drives a 50 % duty square wave at that note's pitch on the speaker pin. On key release the current half-cycle finishes, so the output always returns low cleanly.

---
 rtl/note_tone_gen_if.sv | 28 ++
 rtl/note_tone_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/note_tone_gen_if.sv
// note_tone_gen_if
//   Bundles the key inputs and tone outputs of note_tone_gen.
//   slave  : the tone generator (takes keys, drives tone/status)
//   master : whatever drives the keys and watches the speaker
//   Signals:
//     keys       raw piano buttons, bit 0 = C4 ... bit 7 = C5
//     octave_up  one-octave-up request (only with OCTAVE_SHIFT_EN)
//     tone_out   square-wave speaker drive
//     note_valid high while a note is playing
//     note_idx   index of the note being played
//   Optional feature macro: OCTAVE_SHIFT_EN
interface note_tone_gen_if;
  logic [7:0] keys;
`ifdef OCTAVE_SHIFT_EN
  logic       octave_up;
`endif
  logic       tone_out;
  logic       note_valid;
  logic [2:0] note_idx;

`ifdef OCTAVE_SHIFT_EN
  modport slave  (input  keys, octave_up, output tone_out, note_valid, note_idx);
  modport master (output keys, octave_up, input  tone_out, note_valid, note_idx);
`else
  modport slave  (input  keys,            output tone_out, note_valid, note_idx);
  modport master (output keys,            input  tone_out, note_valid, note_idx);
`endif
endinterface

// File: rtl/note_tone_gen.sv
// note_tone_gen
//   Piano tone generator. Synchronizes and debounces eight key inputs,
//   picks the lowest pressed key, and drives a 50 % duty square wave at
//   that note's pitch. On release the running half-cycle completes so the
//   speaker always ends low.
//   Parameters:
//     DEBOUNCE_CYCLES  stable cycles needed to accept a key pattern (1 .. 2^18-1)
//   Ports:
//     clk_in  25 MHz clock
//     rst_n   asynchronous active-low reset
//     bus     note_tone_gen_if.slave (keys, octave_up, tone_out, note_valid, note_idx)
//   Optional feature macro: OCTAVE_SHIFT_EN
//     defined   -> octave_up halves the half-period, sampled at note start/change
//     undefined -> octave_up absent, half-period used as looked up
module note_tone_gen #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input logic        clk_in,
  input logic        rst_n,
  note_tone_gen_if.slave bus
);

  localparam int NUM_KEYS = 8;
  localparam int SYNC_STAGES = 2;
  localparam logic [17:0] DEB_MAX  = 18'(DEBOUNCE_CYCLES);
  localparam logic [17:0] DEB_LAST = 18'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PLAY, DRAIN} state_t;

  // registered output bundle
  typedef struct packed {
    logic       tone;
    logic [2:0] idx;
  } tone_rsp_t;

  // half-period in clk_in cycles for each key
  function automatic logic [15:0] half_lut(input logic [2:0] i);
    case (i)
      3'd0:    half_lut = 16'd47778; // C4
      3'd1:    half_lut = 16'd42566; // D4
      3'd2:    half_lut = 16'd37921; // E4
      3'd3:    half_lut = 16'd35793; // F4
      3'd4:    half_lut = 16'd31888; // G4
      3'd5:    half_lut = 16'd28409; // A4
      3'd6:    half_lut = 16'd25310; // B4
      default: half_lut = 16'd23889; // C5
    endcase
  endfunction

  // ---------------------------------------------------------------
  // Input synchronizer: key_pipe[0] is the metastability stage
  // ---------------------------------------------------------------
  logic [SYNC_STAGES-1:0][NUM_KEYS-1:0] key_pipe;
  logic [NUM_KEYS-1:0] sync_keys;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) key_pipe <= '0;
    else        key_pipe <= {key_pipe[SYNC_STAGES-2:0], bus.keys};
  end
  assign sync_keys = key_pipe[SYNC_STAGES-1];

`ifdef OCTAVE_SHIFT_EN
  logic [SYNC_STAGES-1:0] oct_pipe;
  logic oct_sync;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) oct_pipe <= '0;
    else        oct_pipe <= {oct_pipe[SYNC_STAGES-2:0], bus.octave_up};
  end
  assign oct_sync = oct_pipe[SYNC_STAGES-1];
`endif

  // ---------------------------------------------------------------
  // Debounce: whole pattern must hold for DEBOUNCE_CYCLES cycles
  // ---------------------------------------------------------------
  logic [NUM_KEYS-1:0] cand, stable_keys;
  logic [17:0] deb_cnt, deb_nxt;

  always_comb begin
    deb_nxt = deb_cnt;
    if (sync_keys != cand)      deb_nxt = '0;
    else if (deb_cnt != DEB_MAX) deb_nxt = deb_cnt + 18'd1;
  end

  // stable_keys loads on the cycle the count reaches DEB_LAST; since the
  // counter saturates above it, that happens once per stable run. With
  // DEBOUNCE_CYCLES = 1 the reload-to-zero cycle itself qualifies, which is
  // why sync_keys (not cand) is captured.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cand        <= '0;
      deb_cnt     <= '0;
      stable_keys <= '0;
    end else begin
      cand    <= sync_keys;
      deb_cnt <= deb_nxt;
      if (deb_nxt == DEB_LAST) stable_keys <= sync_keys;
    end
  end

  // ---------------------------------------------------------------
  // Note select: lowest set bit wins
  // ---------------------------------------------------------------
  logic [2:0]  sel_idx;
  logic [15:0] sel_half;
  logic        any_key;

  always_comb begin
    sel_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (stable_keys[i]) sel_idx = 3'(i);
  end

  assign any_key = |stable_keys;

`ifdef OCTAVE_SHIFT_EN
  assign sel_half = oct_sync ? (half_lut(sel_idx) >> 1) : half_lut(sel_idx);
`else
  assign sel_half = half_lut(sel_idx);
`endif

  // ---------------------------------------------------------------
  // Tone FSM
  // ---------------------------------------------------------------
  state_t      state, state_nxt;
  tone_rsp_t   rsp_q, rsp_nxt;
  logic [15:0] tcnt, tcnt_nxt;
  logic [15:0] half_q, half_nxt;
  logic        at_end;

  // half_q is latched at note start/change so a later octave_up flip
  // waits for the next such event
  assign at_end = (tcnt == half_q - 16'd1);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rsp_q  <= '0;
      tcnt   <= '0;
      half_q <= '0;
    end else begin
      state  <= state_nxt;
      rsp_q  <= rsp_nxt;
      tcnt   <= tcnt_nxt;
      half_q <= half_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rsp_nxt   = rsp_q;
    tcnt_nxt  = tcnt;
    half_nxt  = half_q;
    case (state)
      IDLE: begin
        if (any_key) begin
          state_nxt    = PLAY;
          rsp_nxt.tone = 1'b1;
          rsp_nxt.idx  = sel_idx;
          tcnt_nxt     = '0;
          half_nxt     = sel_half;
        end
      end
      PLAY: begin
        if (any_key && sel_idx != rsp_q.idx) begin
          // level held, restarted with the new note's half-period
          rsp_nxt.idx = sel_idx;
          tcnt_nxt    = '0;
          half_nxt    = sel_half;
        end else begin
          if (!any_key) state_nxt = DRAIN;
          if (at_end) begin
            rsp_nxt.tone = ~rsp_q.tone;
            tcnt_nxt     = '0;
          end else begin
            tcnt_nxt = tcnt + 16'd1;
          end
        end
      end
      DRAIN: begin
        if (any_key) begin
          state_nxt   = PLAY;
          rsp_nxt.idx = sel_idx;
          tcnt_nxt    = '0;
          half_nxt    = sel_half;
        end else if (at_end) begin
          // finishing a high half drops the line; a low half just exits
          state_nxt    = IDLE;
          rsp_nxt.tone = 1'b0;
          tcnt_nxt     = '0;
        end else begin
          tcnt_nxt = tcnt + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.tone_out   = rsp_q.tone;
  assign bus.note_idx   = rsp_q.idx;
  assign bus.note_valid = (state == PLAY);

endmodule
